// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_N_REQ            = 2;
    localparam int unsigned DEF_WORD_SIZE        = 32;
    localparam int unsigned DEF_BLOCK_DATA_WIDTH = 512;
    localparam int unsigned DEF_TIMEOUT_CYCLES   = 64;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

    // Low bit of requester idx's field in a packed per-requester bus.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin winner select: first asserted request at or above ptr, wrapping.
module rr_pick #(
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Scan N_REQ candidates starting at ptr; the first hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block-wide memory port between N_REQ
// cache controllers, one transaction at a time.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort a BUSY transaction
// after TIMEOUT_CYCLES and flag it on req_err.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_REQ            = DEF_N_REQ,
    parameter int unsigned WORD_SIZE        = DEF_WORD_SIZE,
    parameter int unsigned BLOCK_DATA_WIDTH = DEF_BLOCK_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_enable,
    input  logic [N_REQ-1:0]                  req_rw,
    input  logic [N_REQ*WORD_SIZE-1:0]        req_addr,
    input  logic [N_REQ*BLOCK_DATA_WIDTH-1:0] req_dataout,
    output logic [N_REQ-1:0]                  req_ready,
    output logic [BLOCK_DATA_WIDTH-1:0]       req_datain,
    output logic [N_REQ-1:0]                  req_err,
    output logic                              mem_req_enable,
    output logic                              mem_req_rw,
    output logic [WORD_SIZE-1:0]              mem_req_addr,
    output logic [BLOCK_DATA_WIDTH-1:0]       mem_req_dataout,
    input  logic [BLOCK_DATA_WIDTH-1:0]       mem_req_datain,
    input  logic                              mem_req_ready
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] grant;
    logic [N_REQ-1:0] grant_oh;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] ptr_next;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req_enable),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign grant_oh = N_REQ'(1) << grant;
    assign ptr_next = IDX_W'((32'(pick_idx) + 1) % N_REQ);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] wd_cnt;
`else
    assign req_err = '0;
`endif

    // Transaction FSM with registered memory-side and requester-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            grant           <= '0;
            mem_req_enable  <= 1'b0;
            mem_req_rw      <= 1'b0;
            mem_req_addr    <= '0;
            mem_req_dataout <= '0;
            req_ready       <= '0;
            req_datain      <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            req_err         <= '0;
            wd_cnt          <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    req_err   <= '0;
`endif
                    if (pick_valid) begin
                        grant           <= pick_idx;
                        ptr             <= ptr_next;
                        mem_req_rw      <= req_rw[pick_idx];
                        mem_req_addr    <= req_addr[slice_lo(32'(pick_idx), WORD_SIZE) +: WORD_SIZE];
                        mem_req_dataout <= req_dataout[slice_lo(32'(pick_idx), BLOCK_DATA_WIDTH) +: BLOCK_DATA_WIDTH];
                        mem_req_enable  <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                        wd_cnt          <= '0;
`endif
                        state           <= BUSY;
                    end
                end
                BUSY: begin
`ifdef MEM_ARB_TIMEOUT_EN
                    wd_cnt <= wd_cnt + 1'b1;
`endif
                    if (mem_req_ready) begin
                        mem_req_enable <= 1'b0;
                        req_datain     <= mem_req_datain;
                        req_ready      <= grant_oh;
                        state          <= DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mem_req_enable <= 1'b0;
                        req_datain     <= '0;
                        req_ready      <= grant_oh;
                        req_err        <= grant_oh;
                        state          <= DONE;
                    end
`endif
                end
                DONE: begin
                    // Holding here for one cycle lets the served requester drop its request.
                    req_ready <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    req_err   <= '0;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (2 requesters, 512-bit blocks).
module tb_mem_port_arbiter;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned BW = 512;
    localparam int unsigned TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_enable;
    logic [NR-1:0]   req_rw;
    logic [NR*AW-1:0] req_addr;
    logic [NR*BW-1:0] req_dataout;
    logic [NR-1:0]   req_ready;
    logic [BW-1:0]   req_datain;
    logic [NR-1:0]   req_err;
    logic            mem_req_enable;
    logic            mem_req_rw;
    logic [AW-1:0]   mem_req_addr;
    logic [BW-1:0]   mem_req_dataout;
    logic [BW-1:0]   mem_req_datain;
    logic            mem_req_ready;

    mem_port_arbiter #(
        .N_REQ            (NR),
        .WORD_SIZE        (AW),
        .BLOCK_DATA_WIDTH (BW),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_enable      (req_enable),
        .req_rw          (req_rw),
        .req_addr        (req_addr),
        .req_dataout     (req_dataout),
        .req_ready       (req_ready),
        .req_datain      (req_datain),
        .req_err         (req_err),
        .mem_req_enable  (mem_req_enable),
        .mem_req_rw      (mem_req_rw),
        .mem_req_addr    (mem_req_addr),
        .mem_req_dataout (mem_req_dataout),
        .mem_req_datain  (mem_req_datain),
        .mem_req_ready   (mem_req_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   idx;
        logic [AW-1:0] addr;
        logic          rw;
        logic [BW-1:0] wdata;
        logic [BW-1:0] rdata;
    } txn_t;

    txn_t        sb[$];
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [BW-1:0] fill(input logic [31:0] w);
        return {(BW/32){w}};
    endfunction

    function automatic logic [BW-1:0] inc_blk(input logic [31:0] base);
        logic [BW-1:0] b;
        b = '0;
        for (int i = 0; i < BW/32; i++) b[i*32 +: 32] = base + 32'(i);
        return b;
    endfunction

    task automatic issue(input int unsigned idx, input logic rw, input logic [AW-1:0] addr,
                         input logic [BW-1:0] wdata, input logic [BW-1:0] rdata);
        txn_t t;
        req_rw[idx]               = rw;
        req_addr[idx*AW +: AW]    = addr;
        req_dataout[idx*BW +: BW] = wdata;
        req_enable[idx]           = 1'b1;
        t.idx = idx; t.addr = addr; t.rw = rw; t.wdata = wdata; t.rdata = rdata;
        sb.push_back(t);
    endtask

    // Memory model for one transaction: wait for grant, answer after lat cycles.
    task automatic serve(input int unsigned lat, input bit mutate,
                         output int unsigned gcyc, output int unsigned rcyc);
        int unsigned n;
        txn_t t;
        n = 0; gcyc = 0; rcyc = 0;
        while (mem_req_enable !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("grant_seen", mem_req_enable, 1'b1);
        if (mem_req_enable !== 1'b1 || sb.size() == 0) return;
        gcyc = cyc;
        t = sb[0];
        check("mem_addr", mem_req_addr, t.addr);
        check("mem_rw", mem_req_rw, t.rw);
        if (t.rw) check("mem_wdata", mem_req_dataout, t.wdata);
        if (mutate) req_addr[t.idx*AW +: AW] = 32'hBAD0_0000;
        for (int unsigned k = 0; k < lat; k++) begin
            tick();
            check("mem_en_hold", mem_req_enable, 1'b1);
            check("req_ready_quiet", req_ready, '0);
            if (mutate) check("addr_hold", mem_req_addr, t.addr);
        end
        mem_req_ready  = 1'b1;
        mem_req_datain = t.rdata;
        rcyc = cyc;
        tick();
        mem_req_ready  = 1'b0;
        mem_req_datain = '0;
        check("ready_mask", req_ready, NR'(1) << t.idx);
        check("datain", req_datain, t.rdata);
        check("err_clear", req_err, '0);
        check("mem_en_drop", mem_req_enable, 1'b0);
        req_enable[t.idx] = 1'b0;
        void'(sb.pop_front());
        tick();
        check("ready_pulse_end", req_ready, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int unsigned c0, g1, r1, g2, r2, n;

        rst = 1'b1;
        req_enable = '0; req_rw = '0; req_addr = '0; req_dataout = '0;
        mem_req_datain = '0; mem_req_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_mem_en", mem_req_enable, 1'b0);
        check("rst_ready", req_ready, '0);
        check("rst_addr", mem_req_addr, '0);

        // Stray memory ready while idle must do nothing.
        mem_req_ready = 1'b1; mem_req_datain = fill(32'h5555_5555);
        tick();
        mem_req_ready = 1'b0; mem_req_datain = '0;
        tick();
        check("idle_ready_ignored", req_ready, '0);
        check("idle_no_grant", mem_req_enable, 1'b0);
        check("idle_datain_kept", req_datain, '0);

        // Single read by req0; pointer moves to 1.
        issue(0, 1'b0, 32'h000A_0000, '0, fill(32'hFACE_B00C));
        c0 = cyc;
        serve(3, 1'b0, g1, r1);
        check("grant_latency", g1 - c0, 1);
        check("round_trip", r1 - g1, 3);

        // Contention with pointer at 1: req1 first, then req0.
        req_dataout[0 +: BW] = fill(32'h1111_1111);
        issue(1, 1'b0, 32'h0000_1100, '0, fill(32'h0000_00B1));
        issue(0, 1'b0, 32'h0000_0100, '0, fill(32'h0000_00A0));
        sb[0].idx = 1;
        serve(2, 1'b0, g1, r1);
        serve(1, 1'b0, g2, r2);
        check("b2b_gap", g2 - r1, 3);

        // Write-back by req1 while req0 holds a different block on its bus.
        req_dataout[0 +: BW] = fill(32'h1111_1111);
        issue(1, 1'b1, 32'h0002_0040, inc_blk(32'hDEAD_BEEF), fill(32'h7777_0000));
        serve(0, 1'b0, g1, r1);

        // Contention with pointer at 0: req0 first, then req1.
        issue(0, 1'b0, 32'h0000_2000, '0, fill(32'hC0DE_0000));
        issue(1, 1'b0, 32'h0000_3000, '0, fill(32'hC0DE_0001));
        serve(1, 1'b0, g1, r1);
        serve(1, 1'b0, g2, r2);
        check("b2b_gap_2", g2 - r1, 3);

        // Requester address changed mid-transaction.
        issue(0, 1'b0, 32'h0004_4000, '0, fill(32'h4444_AAAA));
        serve(3, 1'b1, g1, r1);

        // Reset while BUSY on req0 (pointer was 1 after that grant).
        issue(0, 1'b1, 32'h0005_5000, fill(32'h9999_9999), '0);
        n = 0;
        while (mem_req_enable !== 1'b1 && n < 20) begin tick(); n++; end
        check("rst_busy_grant", mem_req_enable, 1'b1);
        tick();
        rst = 1'b1;
        req_enable = '0;
        tick();
        rst = 1'b0;
        sb.delete();
        check("rstb_mem_en", mem_req_enable, 1'b0);
        check("rstb_rw", mem_req_rw, 1'b0);
        check("rstb_addr", mem_req_addr, '0);
        check("rstb_wdata", mem_req_dataout, '0);
        check("rstb_ready", req_ready, '0);
        check("rstb_datain", req_datain, '0);
        check("rstb_err", req_err, '0);
        issue(0, 1'b0, 32'h0006_0000, '0, fill(32'h6060_6060));
        issue(1, 1'b0, 32'h0006_1000, '0, fill(32'h6161_6161));
        serve(1, 1'b0, g1, r1);
        serve(1, 1'b0, g2, r2);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: watchdog completes with error and zero data.
        issue(0, 1'b0, 32'h0007_0000, '0, '0);
        c0 = cyc;
        n = 0;
        while (req_ready === '0 && n < 40) begin tick(); n++; end
        check("to_latency", cyc - c0, TO + 1);
        check("to_ready", req_ready, 2'b01);
        check("to_err", req_err, 2'b01);
        check("to_datain", req_datain, '0);
        check("to_mem_en", mem_req_enable, 1'b0);
        req_enable[0] = 1'b0;
        void'(sb.pop_front());
        tick();
        check("to_err_clear", req_err, '0);
        mem_req_ready = 1'b1; mem_req_datain = fill(32'hBBBB_BBBB);
        tick();
        mem_req_ready = 1'b0; mem_req_datain = '0;
        tick();
        check("late_ready_ignored", req_ready, '0);
        check("late_datain_kept", req_datain, '0);
`endif

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
